serial_pe_feeder: RTL and testbench
===================================

# serial_pe_feeder

Bit-serial transmitter that drives one `serial_bitwise_pe` column input of the systolic convolution array. It accepts parallel words over valid/ready handshakes and serializes them LSB-first onto the PE's `xOrW`/`yIn` lines:
- a 6-bit sign-magnitude weight;
- per-sample 8-bit activation X and 16-bit partial sum Y.

It generates the matching `ctrl[2:0]` sequence: LoadW, LSB-of-X marker, circulate.

## Interface
- No parameters; all widths are fixed by the PE and come from the shared package.
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `w_valid` input 1: weight word offered.
- `w_ready` output 1: weight word accepted when `w_valid && w_ready` at a rising edge.
- `w_data` input 6: weight; bit 5 is the sign, bits 4:0 the magnitude.
- `s_valid` input 1: sample offered.
- `s_ready` output 1: sample accepted when `s_valid && s_ready` at a rising edge.
- `x_data` input 8: activation, unsigned.
- `y_data` input 16: incoming partial sum.
- `pe_xw` output 1: serial W/X bit to the PE `xOrW`.
- `pe_y` output 1: serial Y bit to the PE `yIn`.
- `pe_ctrl` output 3: PE control; [2] LSB-of-X, [1] circulate, [0] LoadW.
- `busy` output 1: high in LOAD_W, XPHASE and CPHASE.
- `w_loaded` output 1: set at the end of the first complete weight load; cleared only by reset.

## Operation
- Every serial and control output is registered, i.e. driven from flops.
- FSM states: WAIT_W, LOAD_W, IDLE, XPHASE, CPHASE. A 4-bit bit counter `cnt` runs within each state.
- **WAIT_W** (reset state):
  - `w_ready=1`, `s_ready=0`.
  - Outputs at idle values: `pe_ctrl=3'b010`, `pe_xw=0`, `pe_y=0`.
  - On weight accept, go to LOAD_W with `cnt=0`.
- **LOAD_W** (6 cycles):
  - `pe_ctrl=3'b001`, `pe_xw=w[cnt]`, `pe_y=0`.
  - After `cnt=5`, go to IDLE and set `w_loaded`.
- **IDLE**:
  - Idle output values.
  - On sample accept, go to XPHASE with `cnt=0`.
- **XPHASE** (8 cycles):
  - `pe_xw=x[cnt]`, `pe_y=y[cnt]`.
  - `pe_ctrl=3'b100` at `cnt=0`, `3'b000` at `cnt=1..7`.
- **CPHASE** (8 cycles):
  - `pe_ctrl=3'b010`, `pe_xw=0`, `pe_y=y[8+cnt]`.
  - After `cnt=7`: go to XPHASE if a sample was accepted in that cycle, otherwise IDLE.
- **Accept slot** is high in IDLE, at LOAD_W `cnt=5`, and at CPHASE `cnt=7`.
  - `s_ready = slot && !(w_valid && w_ready_slot)`.
  - Words are captured into holding shift registers on accept. Input data is not sampled again after accept.
- **Simultaneous** `w_valid` and `s_valid` in a slot: the weight wins and the sample waits for the slot at the end of LOAD_W.
- **Reset mid-operation**: at the next edge, FSM goes to WAIT_W, `cnt=0`, outputs take idle values, and `w_loaded=0`. A partially sent word is discarded.

## Timing
- Reset values:
  - `pe_ctrl=3'b010`, `pe_xw=0`, `pe_y=0`.
  - `busy=0`, `w_loaded=0`.
  - `w_ready=1`, `s_ready=0`.
- Latency: a word accepted at edge k puts its bit 0 on `pe_xw`/`pe_y` in the cycle following edge k.
- Weight transfer takes 6 cycles. Sample transfer takes exactly 16 cycles.
- Back-to-back samples run with zero bubbles: one sample every 16 cycles when `s_valid` is held high.
- `w_ready` and `s_ready` are combinational from state, `cnt` and `w_valid`. They have no combinational path from `s_valid`.

## Configuration
- `SERIAL_PE_FEEDER_WRELOAD_EN` defined: `w_ready` is high in WAIT_W and in every accept slot, so the weight can be reloaded between samples.
- Macro undefined: `w_ready` is high only in WAIT_W. After the first load, weights are ignored until reset, and accept slots serve samples only.

## Structure
- Shared package `serial_pe_pkg` holds:
  - width constants `W_BITS=6`, `X_BITS=8`, `Y_BITS=16`;
  - ctrl encodings `CTRL_LOADW=3'b001`, `CTRL_LSBX=3'b100`, `CTRL_SHIFT=3'b000`, `CTRL_CIRC=3'b010`;
  - the FSM state encoding.
- One sub-module, `serial_piso`: a parallel-load, right-shift register with parameterized width and a zero fill.
  - One instance carries W/X, one instance carries Y.
  - Loaded on accept, shifted every busy cycle; output is bit 0.

## Test plan
- **Weight load**: after reset, `w_data=6'b101000` accepted → 6 cycles of `pe_ctrl=001`, `pe_xw`=0,0,0,1,0,1; then `w_loaded=1`.
- **Single sample**: `x_data=8'hB5`, `y_data=16'h5DCD` →
  - `pe_ctrl` = 100, then 000 ×7, then 010 ×8;
  - `pe_xw` = 1,0,1,0,1,1,0,1 then 0 ×8;
  - `pe_y` = 1,0,1,1,0,0,1,1,1,0,1,1,1,0,1,0;
  - then back to idle.
- **Back-to-back**: samples 8'hB5/16'h5DCD and 8'hF0/16'hAAAA with `s_valid` held → 32 contiguous busy cycles; `s_ready` high only in IDLE and in cycle 16.
- **Reset mid-sample**: `reset` asserted at XPHASE `cnt=3` → next cycle `pe_ctrl=010`, `pe_xw=0`, `pe_y=0`, `busy=0`, `w_ready=1`, `w_loaded=0`.
- **Reload priority** (macro defined): `w_valid` and `s_valid` both high in an accept slot → 6 LoadW cycles first, then the sample starts immediately.
- **No reload** (macro undefined): a second `w_valid` after the first load → `w_ready` stays 0; serialized samples are unchanged.

Source files
------------

// File: rtl/serial_pe_pkg.sv
// Shared widths, PE control encodings and FSM state encoding for the
// bit-serial PE feeder.
package serial_pe_pkg;

    localparam int unsigned W_BITS   = 6;
    localparam int unsigned X_BITS   = 8;
    localparam int unsigned Y_BITS   = 16;
    localparam int unsigned CNT_BITS = 4;

    localparam logic [2:0] CTRL_LOADW = 3'b001;
    localparam logic [2:0] CTRL_LSBX  = 3'b100;
    localparam logic [2:0] CTRL_SHIFT = 3'b000;
    localparam logic [2:0] CTRL_CIRC  = 3'b010;

    typedef enum logic [2:0] {
        WAIT_W = 3'd0,
        LOAD_W = 3'd1,
        IDLE   = 3'd2,
        XPHASE = 3'd3,
        CPHASE = 3'd4
    } state_t;

endpackage

// File: rtl/serial_pe_feeder_if.sv
// Word handshakes and serial PE lines of the feeder; master is the word
// source, slave is the feeder itself.
interface serial_pe_feeder_if;
    import serial_pe_pkg::*;

    logic              w_valid;
    logic              w_ready;
    logic [W_BITS-1:0] w_data;
    logic              s_valid;
    logic              s_ready;
    logic [X_BITS-1:0] x_data;
    logic [Y_BITS-1:0] y_data;
    logic              pe_xw;
    logic              pe_y;
    logic [2:0]        pe_ctrl;
    logic              busy;
    logic              w_loaded;

    modport master (
        output w_valid, w_data, s_valid, x_data, y_data,
        input  w_ready, s_ready, pe_xw, pe_y, pe_ctrl, busy, w_loaded
    );

    modport slave (
        input  w_valid, w_data, s_valid, x_data, y_data,
        output w_ready, s_ready, pe_xw, pe_y, pe_ctrl, busy, w_loaded
    );

endinterface

// File: rtl/serial_piso.sv
// Parallel-load, right-shift register with zero fill; serial output is bit 0.
module serial_piso #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_sh;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_data;
        end else if (i_shift) begin
            r_sh <= {1'b0, r_sh[WIDTH-1:1]};
        end
    end

    assign o_bit = r_sh[0];

endmodule

// File: rtl/serial_pe_feeder.sv
// Bit-serial weight/sample transmitter for one serial_bitwise_pe column.
// Define SERIAL_PE_FEEDER_WRELOAD_EN to allow weight reloads in accept slots.
module serial_pe_feeder
    import serial_pe_pkg::*;
(
    input  logic clk,
    input  logic reset,
    serial_pe_feeder_if.slave bus
);

    localparam logic [CNT_BITS-1:0] CNT_W_LAST = CNT_BITS'(W_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_X_LAST = CNT_BITS'(X_BITS - 1);

    state_t              r_state, w_state_nxt;
    logic [CNT_BITS-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]          r_ctrl, w_ctrl_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_w_loaded, w_set_loaded;
    logic                w_slot, w_w_ready, w_s_ready, w_w_acc, w_s_acc;
    logic                w_load_w, w_load_s;
    logic                w_xw_bit, w_y_bit;

    // Accept slots: idle, last weight bit, last circulate bit
    always_comb begin
        w_slot = (r_state == IDLE)
              || (r_state == LOAD_W && r_cnt == CNT_W_LAST)
              || (r_state == CPHASE && r_cnt == CNT_X_LAST);
`ifdef SERIAL_PE_FEEDER_WRELOAD_EN
        w_w_ready = (r_state == WAIT_W) || w_slot;
`else
        w_w_ready = (r_state == WAIT_W);
`endif
        w_s_ready = w_slot && !(bus.w_valid && w_w_ready);
        w_w_acc   = bus.w_valid && w_w_ready;
        w_s_acc   = bus.s_valid && w_s_ready;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_set_loaded = 1'b0;
        w_load_w     = 1'b0;
        w_load_s     = 1'b0;
        unique case (r_state)
            WAIT_W: begin
                w_cnt_nxt = '0;
                if (w_w_acc) begin
                    w_state_nxt = LOAD_W;
                    w_load_w    = 1'b1;
                end
            end
            XPHASE: begin
                if (r_cnt == CNT_X_LAST) begin
                    w_state_nxt = CPHASE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            LOAD_W, IDLE, CPHASE: begin
                if (!w_slot) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_cnt_nxt    = '0;
                    w_set_loaded = (r_state == LOAD_W);
                    if (w_w_acc) begin
                        w_state_nxt = LOAD_W;
                        w_load_w    = 1'b1;
                    end else if (w_s_acc) begin
                        w_state_nxt = XPHASE;
                        w_load_s    = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = WAIT_W;
                w_cnt_nxt   = '0;
            end
        endcase

        // Control is registered, so it is decoded from the next state
        unique case (w_state_nxt)
            LOAD_W:  w_ctrl_nxt = CTRL_LOADW;
            XPHASE:  w_ctrl_nxt = (w_cnt_nxt == '0) ? CTRL_LSBX : CTRL_SHIFT;
            default: w_ctrl_nxt = CTRL_CIRC;
        endcase
        w_busy_nxt = (w_state_nxt == LOAD_W) || (w_state_nxt == XPHASE)
                  || (w_state_nxt == CPHASE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= WAIT_W;
            r_cnt      <= '0;
            r_ctrl     <= CTRL_CIRC;
            r_busy     <= 1'b0;
            r_w_loaded <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_busy     <= w_busy_nxt;
            r_w_loaded <= r_w_loaded | w_set_loaded;
        end
    end

    // W and X share the xOrW line; the weight is zero-extended into the X-wide shifter
    serial_piso #(.WIDTH(X_BITS)) u_piso_xw (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load_w | w_load_s),
        .i_shift (r_busy),
        .i_data  (w_load_w ? X_BITS'(bus.w_data) : bus.x_data),
        .o_bit   (w_xw_bit)
    );

    serial_piso #(.WIDTH(Y_BITS)) u_piso_y (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load_s),
        .i_shift (r_busy),
        .i_data  (bus.y_data),
        .o_bit   (w_y_bit)
    );

    assign bus.w_ready  = w_w_ready;
    assign bus.s_ready  = w_s_ready;
    assign bus.pe_xw    = w_xw_bit;
    assign bus.pe_y     = w_y_bit;
    assign bus.pe_ctrl  = r_ctrl;
    assign bus.busy     = r_busy;
    assign bus.w_loaded = r_w_loaded;

endmodule

// File: tb/tb_serial_pe_feeder.sv
// Directed self-checking bench for serial_pe_feeder; covers the reload or
// no-reload scenario depending on SERIAL_PE_FEEDER_WRELOAD_EN.
module tb_serial_pe_feeder;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    serial_pe_feeder_if bus ();

    serial_pe_feeder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one 16-cycle sample starting in the cycle after accept
    task automatic check_sample(input string name, input logic [7:0] xv, input logic [15:0] yv);
        logic [5:0] exp_v;
        logic [5:0] got_v;
        for (int k = 0; k < 16; k++) begin
            exp_v[5:3] = (k == 0) ? 3'b100 : ((k < 8) ? 3'b000 : 3'b010);
            exp_v[2]   = (k < 8) ? xv[k[2:0]] : 1'b0;
            exp_v[1]   = yv[k[3:0]];
            exp_v[0]   = 1'b1;
            got_v = {bus.pe_ctrl, bus.pe_xw, bus.pe_y, bus.busy};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d {ctrl,xw,y,busy}: got %b expected %b", name, k, got_v, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.pe_ctrl, bus.pe_xw, bus.pe_y, bus.busy, bus.w_loaded, bus.w_ready, bus.s_ready}
            !== 9'b010_0_0_0_0_1_0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b",
                     {bus.pe_ctrl, bus.pe_xw, bus.pe_y, bus.busy, bus.w_loaded, bus.w_ready, bus.s_ready},
                     9'b010_0_0_0_0_1_0);
        end
        reset = 1'b0;
    endtask

    task automatic load_weight(input string name, input logic [5:0] wv);
        bus.w_valid = 1'b1;
        bus.w_data  = wv;
        tick();
        bus.w_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({bus.pe_ctrl, bus.pe_xw, bus.pe_y, bus.busy} !== {3'b001, wv[i], 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL %s bit %0d {ctrl,xw,y,busy}: got %b expected %b", name, i,
                         {bus.pe_ctrl, bus.pe_xw, bus.pe_y, bus.busy}, {3'b001, wv[i], 1'b0, 1'b1});
            end
            tick();
        end
    endtask

    task automatic test_weight_load();
        logic exp_wr;
`ifdef SERIAL_PE_FEEDER_WRELOAD_EN
        exp_wr = 1'b1;
`else
        exp_wr = 1'b0;
`endif
        load_weight("weight_load", 6'b101000);
        n_checks++;
        if ({bus.w_loaded, bus.pe_ctrl, bus.pe_xw, bus.busy, bus.s_ready, bus.w_ready}
            !== {1'b1, 3'b010, 1'b0, 1'b0, 1'b1, exp_wr}) begin
            n_fail++;
            $display("FAIL weight_done {loaded,ctrl,xw,busy,s_rdy,w_rdy}: got %b expected %b",
                     {bus.w_loaded, bus.pe_ctrl, bus.pe_xw, bus.busy, bus.s_ready, bus.w_ready},
                     {1'b1, 3'b010, 1'b0, 1'b0, 1'b1, exp_wr});
        end
    endtask

    task automatic test_single_sample();
        bus.s_valid = 1'b1;
        bus.x_data  = 8'hB5;
        bus.y_data  = 16'h5DCD;
        tick();
        bus.s_valid = 1'b0;
        bus.x_data  = 8'h00;
        bus.y_data  = 16'h0000;
        check_sample("single", 8'b1011_0101, 16'b0101_1101_1100_1101);
        n_checks++;
        if ({bus.pe_ctrl, bus.busy, bus.pe_xw, bus.pe_y, bus.s_ready} !== 7'b010_0_0_0_1) begin
            n_fail++;
            $display("FAIL single_idle {ctrl,busy,xw,y,s_rdy}: got %b expected %b",
                     {bus.pe_ctrl, bus.busy, bus.pe_xw, bus.pe_y, bus.s_ready}, 7'b010_0_0_0_1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  xv;
        logic [15:0] yv;
        logic [6:0]  exp_v;
        logic [6:0]  got_v;
        int          k;
        bus.s_valid = 1'b1;
        bus.x_data  = 8'hB5;
        bus.y_data  = 16'h5DCD;
        tick();
        bus.x_data  = 8'hF0;
        bus.y_data  = 16'hAAAA;
        for (int j = 0; j < 32; j++) begin
            k  = j % 16;
            xv = (j < 16) ? 8'hB5 : 8'hF0;
            yv = (j < 16) ? 16'h5DCD : 16'hAAAA;
            exp_v[6:4] = (k == 0) ? 3'b100 : ((k < 8) ? 3'b000 : 3'b010);
            exp_v[3]   = (k < 8) ? xv[k[2:0]] : 1'b0;
            exp_v[2]   = yv[k[3:0]];
            exp_v[1]   = 1'b1;
            exp_v[0]   = (k == 15);
            got_v = {bus.pe_ctrl, bus.pe_xw, bus.pe_y, bus.busy, bus.s_ready};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL b2b cycle %0d {ctrl,xw,y,busy,s_rdy}: got %b expected %b", j + 1, got_v, exp_v);
            end
            tick();
            if (j == 15) bus.s_valid = 1'b0;
        end
        n_checks++;
        if ({bus.busy, bus.pe_ctrl} !== 4'b0_010) begin
            n_fail++;
            $display("FAIL b2b_idle {busy,ctrl}: got %b expected %b", {bus.busy, bus.pe_ctrl}, 4'b0_010);
        end
    endtask

    task automatic test_reset_mid_sample();
        bus.s_valid = 1'b1;
        bus.x_data  = 8'hFF;
        bus.y_data  = 16'hFFFF;
        tick();
        bus.s_valid = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if ({bus.pe_ctrl, bus.pe_xw, bus.pe_y} !== 5'b000_1_1) begin
            n_fail++;
            $display("FAIL mid_cnt3 {ctrl,xw,y}: got %b expected %b", {bus.pe_ctrl, bus.pe_xw, bus.pe_y}, 5'b000_1_1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({bus.pe_ctrl, bus.pe_xw, bus.pe_y, bus.busy, bus.w_ready, bus.w_loaded, bus.s_ready}
            !== 9'b010_0_0_0_1_0_0) begin
            n_fail++;
            $display("FAIL mid_reset {ctrl,xw,y,busy,w_rdy,loaded,s_rdy}: got %b expected %b",
                     {bus.pe_ctrl, bus.pe_xw, bus.pe_y, bus.busy, bus.w_ready, bus.w_loaded, bus.s_ready},
                     9'b010_0_0_0_1_0_0);
        end
        tick();
        n_checks++;
        if ({bus.busy, bus.pe_xw, bus.pe_y} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_discard {busy,xw,y}: got %b expected %b", {bus.busy, bus.pe_xw, bus.pe_y}, 3'b000);
        end
    endtask

`ifdef SERIAL_PE_FEEDER_WRELOAD_EN
    task automatic test_reload_priority();
        load_weight("reload_first", 6'b010101);
        bus.w_valid = 1'b1;
        bus.w_data  = 6'b110011;
        bus.s_valid = 1'b1;
        bus.x_data  = 8'hB5;
        bus.y_data  = 16'h5DCD;
        n_checks++;
        if ({bus.w_ready, bus.s_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL reload_slot {w_rdy,s_rdy}: got %b expected %b", {bus.w_ready, bus.s_ready}, 2'b10);
        end
        tick();
        bus.w_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({bus.pe_ctrl, bus.pe_xw, bus.s_ready} !== {3'b001, bus.w_data[i], (i == 5)}) begin
                n_fail++;
                $display("FAIL reload_w bit %0d {ctrl,xw,s_rdy}: got %b expected %b", i,
                         {bus.pe_ctrl, bus.pe_xw, bus.s_ready}, {3'b001, bus.w_data[i], (i == 5)});
            end
            tick();
        end
        bus.s_valid = 1'b0;
        check_sample("reload_sample", 8'b1011_0101, 16'b0101_1101_1100_1101);
    endtask
`else
    task automatic test_no_reload();
        load_weight("noreload_first", 6'b010101);
        bus.w_valid = 1'b1;
        bus.w_data  = 6'b111111;
        bus.s_valid = 1'b1;
        bus.x_data  = 8'hB5;
        bus.y_data  = 16'h5DCD;
        n_checks++;
        if ({bus.w_ready, bus.s_ready, bus.w_loaded} !== 3'b011) begin
            n_fail++;
            $display("FAIL noreload_slot {w_rdy,s_rdy,loaded}: got %b expected %b",
                     {bus.w_ready, bus.s_ready, bus.w_loaded}, 3'b011);
        end
        tick();
        bus.s_valid = 1'b0;
        check_sample("noreload_sample", 8'b1011_0101, 16'b0101_1101_1100_1101);
        n_checks++;
        if ({bus.w_ready, bus.busy, bus.pe_ctrl} !== 5'b0_0_010) begin
            n_fail++;
            $display("FAIL noreload_idle {w_rdy,busy,ctrl}: got %b expected %b",
                     {bus.w_ready, bus.busy, bus.pe_ctrl}, 5'b0_0_010);
        end
        bus.w_valid = 1'b0;
    endtask
`endif

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.s_valid = 1'b0;
        bus.x_data  = '0;
        bus.y_data  = '0;
        test_reset();
        test_weight_load();
        test_single_sample();
        test_back_to_back();
        test_reset_mid_sample();
`ifdef SERIAL_PE_FEEDER_WRELOAD_EN
        test_reload_priority();
`else
        test_no_reload();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
